// File: rtl/rvfi_retire_sequencer.sv
// Turns raw per-channel retirement strobes into a registered RVFI packet stream
// with globally ordered rvfi_order values and a one-shot check strobe.
module rvfi_retire_sequencer #(
  parameter int NRET          = 1,
  parameter int CHECK_CYCLE   = 20,
  parameter int CHECK_CHANNEL = 0
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NRET-1:0]      in_retire,
  input  logic                 in_flush,
  input  logic [32*NRET-1:0]   in_insn,
  input  logic [5*NRET-1:0]    in_rs1_addr,
  input  logic [5*NRET-1:0]    in_rs2_addr,
  input  logic [5*NRET-1:0]    in_rd_addr,
  input  logic [NRET-1:0]      in_rd_we,
  output logic [NRET-1:0]      rvfi_valid,
  output logic [64*NRET-1:0]   rvfi_order,
  output logic [32*NRET-1:0]   rvfi_insn,
  output logic [5*NRET-1:0]    rvfi_rs1_addr,
  output logic [5*NRET-1:0]    rvfi_rs2_addr,
  output logic [5*NRET-1:0]    rvfi_rd_addr,
  output logic                 check
);

  localparam logic [15:0] CHECK_CYC = 16'(CHECK_CYCLE);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_ARMED = 2'd1,
    ST_FIRED = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [15:0]             cyc_q, cyc_d;
  logic [63:0]             base_q, base_d;
  logic [63:0]             order_run;
  logic [NRET-1:0]         retire_eff;
  logic [NRET-1:0]         valid_q, valid_d;
  logic [NRET-1:0][63:0]   order_q, order_d;
  logic [NRET-1:0][31:0]   insn_q, insn_d;
  logic [NRET-1:0][4:0]    rs1_q, rs1_d;
  logic [NRET-1:0][4:0]    rs2_q, rs2_d;
  logic [NRET-1:0][4:0]    rd_q, rd_d;
  logic                    check_q, check_d;

  // Flush suppresses every retirement sampled on this edge.
  always_comb begin
    if (in_flush) begin
      retire_eff = {NRET{1'b0}};
    end else begin
      retire_eff = in_retire;
    end
  end

  // Packet fields; orders are handed out lowest channel first from the base.
  always_comb begin
    order_run = base_q;
    valid_d   = retire_eff;
    order_d   = {NRET{64'd0}};
    insn_d    = {NRET{32'd0}};
    rs1_d     = {NRET{5'd0}};
    rs2_d     = {NRET{5'd0}};
    rd_d      = {NRET{5'd0}};
    for (int i = 0; i < NRET; i++) begin
      if (retire_eff[i]) begin
        order_d[i] = order_run;
        insn_d[i]  = in_insn[32*i +: 32];
        rs1_d[i]   = in_rs1_addr[5*i +: 5];
        rs2_d[i]   = in_rs2_addr[5*i +: 5];
        if (in_rd_we[i]) begin
          rd_d[i] = in_rd_addr[5*i +: 5];
        end else begin
          rd_d[i] = 5'd0;
        end
        order_run = order_run + 64'd1;
      end else begin
        order_d[i] = 64'd0;
        insn_d[i]  = 32'd0;
        rs1_d[i]   = 5'd0;
        rs2_d[i]   = 5'd0;
        rd_d[i]    = 5'd0;
      end
    end
    base_d = order_run;
  end

  // Edge counter saturating at the check threshold.
  always_comb begin
    if (cyc_q == CHECK_CYC) begin
      cyc_d = cyc_q;
    end else begin
      cyc_d = cyc_q + 16'd1;
    end
  end

  // Next-state logic for the check sequencer.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN: begin
        if (cyc_d == CHECK_CYC) begin
          state_d = ST_ARMED;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_ARMED: begin
        if (retire_eff[CHECK_CHANNEL]) begin
          state_d = ST_FIRED;
        end else begin
          state_d = ST_ARMED;
        end
      end
      ST_FIRED: state_d = ST_FIRED;
      default:  state_d = ST_FIRED;
    endcase
  end

  // Check strobe rides with the first checked-channel packet while armed.
  always_comb begin
    check_d = 1'b0;
    case (state_q)
      ST_ARMED: check_d = retire_eff[CHECK_CHANNEL];
      ST_RUN:   check_d = 1'b0;
      ST_FIRED: check_d = 1'b0;
      default:  check_d = 1'b0;
    endcase
  end

  // Sequencer state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_RUN;
      cyc_q   <= 16'd0;
      check_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      check_q <= check_d;
    end
  end

  // Packet and order-base registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      base_q  <= 64'd0;
      valid_q <= {NRET{1'b0}};
      order_q <= {NRET{64'd0}};
      insn_q  <= {NRET{32'd0}};
      rs1_q   <= {NRET{5'd0}};
      rs2_q   <= {NRET{5'd0}};
      rd_q    <= {NRET{5'd0}};
    end else begin
      base_q  <= base_d;
      valid_q <= valid_d;
      order_q <= order_d;
      insn_q  <= insn_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
      rd_q    <= rd_d;
    end
  end

  assign rvfi_valid    = valid_q;
  assign rvfi_order    = order_q;
  assign rvfi_insn     = insn_q;
  assign rvfi_rs1_addr = rs1_q;
  assign rvfi_rs2_addr = rs2_q;
  assign rvfi_rd_addr  = rd_q;
  assign check         = check_q;

endmodule
